branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage RISC-V pipeline, replacing the static always-not-taken fetch policy. It sits in IF and supplies the next-fetch PC from a direct-mapped BTB and 2-bit saturating counters. It is trained from EX by the resolved outcome: the ALU branch condition for conditional branches, and taken for JAL/JALR. Misprediction detection and flush remain in the hazard/PC-select logic.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Define BRANCH_PRED_GSHARE_EN to fold a global history register into the index (bimodal otherwise).
module branch_predictor #(
    parameter int unsigned ENTRY_BITS = 5,
    parameter int unsigned HIST_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           if_pc,
    output logic [31:0]           pred_pc,
    output logic                  pred_taken,
    output logic [ENTRY_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic                  upd_is_branch,
    input  logic [31:0]           upd_pc,
    input  logic [ENTRY_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target
);

    localparam int unsigned ENTRIES = 1 << ENTRY_BITS;
    localparam int unsigned TAG_W   = 32 - ENTRY_BITS - 2;

    if (HIST_BITS > ENTRY_BITS) begin : g_hist_check
        $error("HIST_BITS must not exceed ENTRY_BITS");
    end

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [ENTRY_BITS-1:0] lk_index;
    logic                  lk_hit;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic [1:0]            upd_ctr;
    logic                  unused_upd_pc_low;

    assign upd_tag           = upd_pc[31:ENTRY_BITS+2];
    assign unused_upd_pc_low = ^upd_pc[ENTRY_BITS+1:0];

`ifdef BRANCH_PRED_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] hist;

    // History shifts only on resolved conditional branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (upd_valid && upd_is_branch) begin
            ghr_q <= {ghr_q[HIST_BITS-2:0], upd_taken};
        end
    end

    assign hist     = reset ? '0 : ghr_q;
    assign lk_index = if_pc[ENTRY_BITS+1:2] ^ ENTRY_BITS'(hist);
`else
    assign lk_index = if_pc[ENTRY_BITS+1:2];
`endif

    // Lookup sees pre-update state; reset masks any stale hit in the reset cycle.
    always_comb begin
        lk_hit     = valid_q[lk_index] && (tag_q[lk_index] == if_pc[31:ENTRY_BITS+2]);
        pred_taken = !reset && lk_hit && ctr_q[lk_index][1];
        pred_pc    = pred_taken ? target_q[lk_index] : if_pc + 32'd4;
        pred_index = lk_index;
    end

    // Next counter value for the entry named by upd_index.
    always_comb begin
        upd_hit = valid_q[upd_index] && (tag_q[upd_index] == upd_tag);
        upd_ctr = ctr_q[upd_index];
        if (!upd_hit) begin
            upd_ctr = upd_is_branch ? 2'b10 : 2'b11;
        end else if (!upd_is_branch) begin
            upd_ctr = 2'b11;
        end else if (upd_taken) begin
            upd_ctr = (ctr_q[upd_index] == 2'b11) ? 2'b11 : ctr_q[upd_index] + 2'd1;
        end else begin
            upd_ctr = (ctr_q[upd_index] == 2'b00) ? 2'b00 : ctr_q[upd_index] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_valid && (upd_hit || upd_taken)) begin
            valid_q[upd_index] <= 1'b1;
            ctr_q[upd_index]   <= upd_ctr;
        end
    end

    // Tag and target carry no reset: they are only meaningful behind valid.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            target_q[upd_index] <= upd_target;
            if (!upd_hit) begin
                tag_q[upd_index] <= upd_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table plus randomized traffic
// compared against a table-level reference model.
module tb_branch_predictor;

    localparam int unsigned EB = 5;
    localparam int unsigned NE = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   if_pc;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [EB-1:0] pred_index;
    logic          upd_valid;
    logic          upd_is_branch;
    logic [31:0]   upd_pc;
    logic [EB-1:0] upd_index;
    logic          upd_taken;
    logic [31:0]   upd_target;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRY_BITS(EB), .HIST_BITS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .pred_index   (pred_index),
        .upd_valid    (upd_valid),
        .upd_is_branch(upd_is_branch),
        .upd_pc       (upd_pc),
        .upd_index    (upd_index),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    // Reference model: one record per table slot, plain integers.
    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    int unsigned m_tgt   [NE];
    int          m_ctr   [NE];
    int unsigned m_ghr;

    function automatic int unsigned m_index(input int unsigned pc, input bit r);
        int unsigned h;
        h = 0;
`ifdef BRANCH_PRED_GSHARE_EN
        if (!r) h = m_ghr;
`endif
        return ((pc >> 2) ^ h) % NE;
    endfunction

    function automatic bit m_taken(input int unsigned pc, input bit r);
        int unsigned i;
        i = m_index(pc, r);
        return !r && m_valid[i] && (m_tag[i] == (pc >> 7)) && (m_ctr[i] >= 2);
    endfunction

    function automatic int unsigned m_next_pc(input int unsigned pc, input bit r);
        return m_taken(pc, r) ? m_tgt[m_index(pc, r)] : pc + 4;
    endfunction

    task automatic m_clock();
        int unsigned i;
        if (reset) begin
            for (int k = 0; k < NE; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
            m_ghr = 0;
        end else if (upd_valid) begin
            i = upd_index;
            if (!(m_valid[i] && m_tag[i] == (upd_pc >> 7))) begin
                if (upd_taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = upd_pc >> 7;
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = upd_is_branch ? 2 : 3;
                end
            end else begin
                if (upd_taken) m_tgt[i] = upd_target;
                if (!upd_is_branch)  m_ctr[i] = 3;
                else if (upd_taken)  m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else                 m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
            if (upd_is_branch) m_ghr = ((m_ghr << 1) | int'(upd_taken)) % NE;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic uv, input logic ub,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        reset         = r;
        if_pc         = pc;
        upd_valid     = uv;
        upd_is_branch = ub;
        upd_pc        = upc;
        upd_taken     = ut;
        upd_target    = utgt;
        upd_index     = EB'(m_index(upc, r));
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        uv;
        logic        ub;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        e_taken;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [23];

    initial begin
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

`ifndef BRANCH_PRED_GSHARE_EN
        //          rst   pc            uv    ub    upc           ut    utgt          taken pc
        vt[0]  = '{1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0044};
        vt[1]  = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0044};
        vt[2]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0044};
        vt[3]  = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
        vt[4]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
        vt[5]  = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0044};
        vt[6]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0044};
        vt[7]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010};
        vt[8]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010};
        vt[9]  = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010};
        vt[10] = '{1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
        vt[11] = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
        vt[12] = '{1'b0, 32'h0000_00C0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00C4};
        vt[13] = '{1'b0, 32'h0000_00C0, 1'b1, 1'b1, 32'h0000_00C0, 1'b0, 32'h0000_0998, 1'b0, 32'h0000_00C4};
        vt[14] = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
        vt[15] = '{1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0104};
        vt[16] = '{1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0200};
        vt[17] = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0300};
        vt[18] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0104};
        vt[19] = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0104};
        vt[20] = '{1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0044};
        vt[21] = '{1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vt[22] = '{1'b0, 32'h0000_00C0, 1'b1, 1'b1, 32'h0000_00C0, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_00C4};

        for (int v = 0; v < 23; v++) begin
            drive(vt[v].rst, vt[v].pc, vt[v].uv, vt[v].ub, vt[v].upc, vt[v].ut, vt[v].utgt);
            #4;
            chk($sformatf("vec%0d_taken", v), 32'(pred_taken), 32'(vt[v].e_taken));
            chk($sformatf("vec%0d_pc", v), pred_pc, vt[v].e_pc);
            chk($sformatf("vec%0d_index", v), 32'(pred_index), (vt[v].pc >> 2) & 32'd31);
            tick();
        end
        // Alias 0xC0 now owns index 16; 0x40 must miss.
        drive(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #4;
        chk("alias_evict_pc", pred_pc, 32'h44);
        tick();
`else
        // Alternating T/N on one branch: history separates the two outcomes onto two slots.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, (k % 2) == 0, 32'h10);
            #4;
            if (k >= 12) begin
                chk($sformatf("gshare_alt%0d_taken", k), 32'(pred_taken), 32'((k % 2) == 0));
            end
            chk($sformatf("gshare_alt%0d_index", k), 32'(pred_index), m_index(32'h40, 1'b0));
            tick();
        end
`endif

        // Randomized traffic on a small PC pool to force hits, misses and aliasing.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, upc, tgt;
            logic        r, uv, ub, ut;
            pc  = (($urandom % 4) << 7) | (($urandom % 8) << 2);
            upc = (($urandom % 4) << 7) | (($urandom % 8) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            r   = ($urandom % 50) == 0;
            uv  = ($urandom % 3) != 0;
            ub  = ($urandom % 4) != 0;
            ut  = ub ? 1'($urandom % 2) : 1'b1;
            drive(r, pc, uv, ub, upc, ut, tgt);
            #4;
            chk($sformatf("rnd%0d_taken", n), 32'(pred_taken), 32'(m_taken(pc, r)));
            chk($sformatf("rnd%0d_pc", n), pred_pc, m_next_pc(pc, r));
            chk($sformatf("rnd%0d_index", n), 32'(pred_index), m_index(pc, r));
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
